fetch_queue: RTL and testbench

- Small instruction buffer between the fetch stage (PC register plus instruction memory read) and decode.
- Decouples fetch from decode stalls: fetch pushes {pc, instr} pairs, decode pops them in order over a valid/ready handshake.
- A synchronous flush discards all buffered entries when the PC is redirected by a taken branch, jump or exception.

---
 rtl/fetch_queue.sv | 81 ++++++++
 tb/tb_fetch_queue.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: in-order {pc, instr} buffer between fetch and decode.
// Registered storage, valid/ready on both sides, synchronous flush.
module fetch_queue #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDRESS_WIDTH-1:0]   in_pc,
    input  logic [DATA_WIDTH-1:0]      in_instr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ADDRESS_WIDTH-1:0]   out_pc,
    output logic [DATA_WIDTH-1:0]      out_instr,
    output logic [ADDRESS_WIDTH-1:0]   out_pc_plus4,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] LP_FULL = (PW+1)'(DEPTH);

    logic [ADDRESS_WIDTH-1:0] r_pc    [DEPTH];
    logic [DATA_WIDTH-1:0]    r_instr [DEPTH];
    logic [PW-1:0]            r_wptr;
    logic [PW-1:0]            r_rptr;
    logic [PW:0]              r_count;

    logic w_push;
    logic w_pop;
    logic w_empty;

    assign w_empty   = (r_count == '0);
    assign in_ready  = (r_count < LP_FULL);
    assign out_valid = !w_empty;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign count     = r_count;

    // An empty queue presents zeros rather than stale storage.
    assign out_pc       = w_empty ? '0 : r_pc[r_rptr];
    assign out_instr    = w_empty ? '0 : r_instr[r_rptr];
    assign out_pc_plus4 = out_pc + ADDRESS_WIDTH'(4);

    // Storage write: plain registers, no reset, left stale on flush.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc[r_wptr]    <= in_pc;
            r_instr[r_wptr] <= in_instr;
        end
    end

    // Pointer/occupancy update; reset beats flush beats handshakes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed plus random stimulus against a queue-based
// reference model of the fetch buffer.
module tb_fetch_queue;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_pc;
    logic [DW-1:0] in_instr;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_pc;
    logic [DW-1:0] out_instr;
    logic [AW-1:0] out_pc_plus4;
    logic [CW-1:0] count;

    int checks   = 0;
    int failures = 0;

    logic [AW-1:0] m_pc    [$];
    logic [DW-1:0] m_instr [$];

    fetch_queue #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH   (DW),
        .DEPTH        (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pc       (in_pc),
        .in_instr    (in_instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_instr   (out_instr),
        .out_pc_plus4(out_pc_plus4),
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int            n;
        logic [AW-1:0] hp;
        logic [DW-1:0] hi;
        n  = m_pc.size();
        hp = (n != 0) ? m_pc[0] : '0;
        hi = (n != 0) ? m_instr[0] : '0;
        chk({tag, ".count"}, 32'(count), 32'(n));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(n != 0));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(n < DEPTH));
        chk({tag, ".out_pc"}, out_pc, hp);
        chk({tag, ".out_instr"}, out_instr, hi);
        chk({tag, ".out_pc_plus4"}, out_pc_plus4, hp + 32'd4);
    endtask

    // Drive one cycle, advance the model at the edge, check at negedge.
    task automatic step(input logic r, input logic f, input logic iv,
                        input logic [AW-1:0] pc, input logic [DW-1:0] ins,
                        input logic ordy, input string tag);
        bit do_push;
        bit do_pop;
        rst       = r;
        flush     = f;
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = ordy;
        @(posedge clk);
        do_push = iv && (m_pc.size() < DEPTH);
        do_pop  = ordy && (m_pc.size() > 0);
        if (!r || f) begin
            m_pc.delete();
            m_instr.delete();
        end else begin
            if (do_pop) begin
                void'(m_pc.pop_front());
                void'(m_instr.pop_front());
            end
            if (do_push) begin
                m_pc.push_back(pc);
                m_instr.push_back(ins);
            end
        end
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_instr  = '0;
        out_ready = 1'b0;
        @(negedge clk);

        step(0, 0, 0, 0, 0, 0, "rst0");
        step(0, 0, 0, 0, 0, 0, "rst1");
        step(1, 0, 0, 0, 0, 0, "idle");

        step(1, 0, 1, 32'h0, 32'h00500093, 1, "pass_push");
        chk("pass_pc4", out_pc_plus4, 32'h4);
        step(1, 0, 0, 0, 0, 1, "pass_pop");

        step(1, 0, 1, 32'h10, 32'hA, 0, "fill0");
        step(1, 0, 1, 32'h14, 32'hB, 0, "fill1");
        chk("fill_ready", 32'(in_ready), 32'h0);
        step(1, 0, 1, 32'h18, 32'hC, 0, "fill_ovf");
        chk("fill_head", out_pc, 32'h10);
        step(1, 0, 0, 0, 0, 1, "drain0");
        chk("drain_head", out_pc, 32'h14);
        step(1, 0, 0, 0, 0, 1, "drain1");

        step(1, 0, 1, 32'h20, 32'h100, 0, "sim_seed");
        for (int k = 0; k < 8; k++) begin
            step(1, 0, 1, 32'h24 + 32'(4 * k), 32'h200 + 32'(k), 1, "sim");
        end
        chk("sim_head", out_pc, 32'h40);
        step(1, 0, 0, 0, 0, 1, "sim_drain");

        step(1, 0, 1, 32'h30, 32'h1, 0, "fl_a");
        step(1, 0, 1, 32'h34, 32'h2, 0, "fl_b");
        step(1, 1, 1, 32'h100, 32'h3, 1, "flush");
        chk("flush_cnt", 32'(count), 32'h0);
        step(1, 0, 1, 32'h100, 32'h3, 0, "fl_push");
        chk("flush_head", out_pc, 32'h100);

        step(1, 1, 0, 0, 0, 0, "wr_flush");
        step(1, 0, 1, 32'hFFFFFFFC, 32'h13, 0, "wrap");
        chk("wrap_pc4", out_pc_plus4, 32'h0);
        step(1, 0, 1, 32'h8, 32'h14, 0, "wrap_fill");
        step(0, 0, 1, 32'hC, 32'h15, 1, "mid_rst");
        chk("mid_rst_rdy", 32'(in_ready), 32'h1);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 63) != 0),
                 ($urandom_range(0, 15) == 0),
                 1'($urandom), $urandom, $urandom,
                 1'($urandom), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
